// File: rtl/led_status_ctrl.sv
// led_status_ctrl: per-channel LED pattern generator with a debounced user
// button that toggles a lamp-test override. All LED outputs are registered.
module led_status_ctrl #(
  parameter int NUM_LEDS        = 6,
  parameter int CNT_W           = 25,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int FLASH_CYCLES    = 2700000,
  parameter int LED_ACTIVE_LOW  = 1
) (
  input  logic                clk_27m,
  input  logic                rst_n,
  input  logic                btn_user,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [2:0]          cfg_mode,
  input  logic [2:0]          cfg_arg,
  input  logic [NUM_LEDS-1:0] event_i,
  output logic [NUM_LEDS-1:0] led,
  output logic                btn_press,
  output logic                lamp_test
);

  localparam int TW = $clog2(FLASH_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [NUM_LEDS-1:0] LED_POL = (LED_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [2:0] {
    MODE_OFF        = 3'd0,
    MODE_ON         = 3'd1,
    MODE_BLINK_SLOW = 3'd2,
    MODE_BLINK_FAST = 3'd3,
    MODE_BURST      = 3'd4,
    MODE_ONESHOT    = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    REL,
    PRESS_WAIT,
    PRESSED,
    REL_WAIT
  } db_state_e;

  logic [CNT_W-1:0]    cnt;
  logic [3:0]          slot;
  logic [2:0]          mode_q  [NUM_LEDS];
  logic [2:0]          arg_q   [NUM_LEDS];
  logic [TW-1:0]       timer_q [NUM_LEDS];
  logic [NUM_LEDS-1:0] lit;
  logic                sync1, sync2;
  db_state_e           db_state;
  logic [DW-1:0]       db_cnt;

  assign slot = cnt[CNT_W-1 -: 4];

  // Free-running prescaler shared by all blink/burst patterns
  always_ff @(posedge clk_27m or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + CNT_W'(1);
  end

  // Channel configuration registers; out-of-range addresses match no channel
  always_ff @(posedge clk_27m or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_LEDS; k++) begin
        mode_q[k] <= (k == 0) ? MODE_BLINK_SLOW : MODE_OFF;
        arg_q[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_LEDS; k++) begin
        if (cfg_we && (cfg_addr == 3'(k))) begin
          mode_q[k] <= cfg_mode;
          arg_q[k]  <= cfg_arg;
        end
      end
    end
  end

  // One-shot timers: load on event (any mode), otherwise count down to zero
  always_ff @(posedge clk_27m or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_LEDS; k++) timer_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_LEDS; k++) begin
        if (event_i[k])               timer_q[k] <= TW'(FLASH_CYCLES);
        else if (timer_q[k] != '0)    timer_q[k] <= timer_q[k] - TW'(1);
      end
    end
  end

  // Per-channel lit decision; lamp test overrides without stopping the channels
  always_comb begin
    lit = '0;
    for (int unsigned k = 0; k < NUM_LEDS; k++) begin
      case (mode_q[k])
        MODE_ON:         lit[k] = 1'b1;
        MODE_BLINK_SLOW: lit[k] = cnt[CNT_W-1];
        MODE_BLINK_FAST: lit[k] = cnt[CNT_W-3];
        MODE_BURST:      lit[k] = ~slot[0] && (slot[3:1] < arg_q[k]);
        MODE_ONESHOT:    lit[k] = (timer_q[k] != '0);
        default:         lit[k] = 1'b0;
      endcase
    end
    if (lamp_test) lit = '1;
  end

  // Two-flop synchronizer for the raw button, idling at the released level
  always_ff @(posedge clk_27m or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_user;
      sync2 <= sync1;
    end
  end

  // Debounce FSM; the sample that leaves a stable state counts as the first
  // of the DEBOUNCE_CYCLES consecutive samples needed to change level
  always_ff @(posedge clk_27m or negedge rst_n) begin
    if (!rst_n) begin
      db_state  <= REL;
      db_cnt    <= '0;
      btn_press <= 1'b0;
      lamp_test <= 1'b0;
    end else begin
      btn_press <= 1'b0;
      case (db_state)
        REL: begin
          if (!sync2) begin
            db_state <= PRESS_WAIT;
            db_cnt   <= DW'(1);
          end
        end
        PRESS_WAIT: begin
          if (sync2) begin
            db_state <= REL;
            db_cnt   <= '0;
          end else if (db_cnt >= DW'(DEBOUNCE_CYCLES - 1)) begin
            db_state  <= PRESSED;
            db_cnt    <= '0;
            btn_press <= 1'b1;
            lamp_test <= ~lamp_test;
          end else begin
            db_cnt <= db_cnt + DW'(1);
          end
        end
        PRESSED: begin
          if (sync2) begin
            db_state <= REL_WAIT;
            db_cnt   <= DW'(1);
          end
        end
        REL_WAIT: begin
          if (!sync2) begin
            db_state <= PRESSED;
            db_cnt   <= '0;
          end else if (db_cnt >= DW'(DEBOUNCE_CYCLES - 1)) begin
            db_state <= REL;
            db_cnt   <= '0;
          end else begin
            db_cnt <= db_cnt + DW'(1);
          end
        end
        default: begin
          db_state <= REL;
          db_cnt   <= '0;
        end
      endcase
    end
  end

  // Registered LED drive with output polarity applied
  always_ff @(posedge clk_27m or negedge rst_n) begin
    if (!rst_n) led <= LED_POL;
    else        led <= lit ^ LED_POL;
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Randomized self-checking bench for led_status_ctrl against a cycle-level
// behavioural model derived from the channel and debounce rules.
module tb_led_status_ctrl;

  localparam int NL = 6;
  localparam int CW = 8;
  localparam int DB = 4;
  localparam int FL = 10;

  logic          clk_27m = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn_user = 1'b1;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_addr = '0;
  logic [2:0]    cfg_mode = '0;
  logic [2:0]    cfg_arg = '0;
  logic [NL-1:0] event_i = '0;
  logic [NL-1:0] led;
  logic          btn_press;
  logic          lamp_test;

  led_status_ctrl #(
    .NUM_LEDS(NL),
    .CNT_W(CW),
    .DEBOUNCE_CYCLES(DB),
    .FLASH_CYCLES(FL),
    .LED_ACTIVE_LOW(1)
  ) dut (
    .clk_27m(clk_27m),
    .rst_n(rst_n),
    .btn_user(btn_user),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_mode(cfg_mode),
    .cfg_arg(cfg_arg),
    .event_i(event_i),
    .led(led),
    .btn_press(btn_press),
    .lamp_test(lamp_test)
  );

  always #5 clk_27m = ~clk_27m;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  int            m_cnt;
  int            m_mode  [NL];
  int            m_arg   [NL];
  int            m_timer [NL];
  bit            m_lamp;
  bit            m_press;
  logic [NL-1:0] m_led;
  bit            m_d1, m_d2;
  bit            m_held;
  int            m_run;

  function automatic void model_reset();
    m_cnt = 0;
    for (int k = 0; k < NL; k++) begin
      m_mode[k]  = (k == 0) ? 2 : 0;
      m_arg[k]   = 0;
      m_timer[k] = 0;
    end
    m_lamp  = 0;
    m_press = 0;
    m_led   = '1;
    m_d1    = 1;
    m_d2    = 1;
    m_held  = 0;
    m_run   = 0;
  endfunction

  function automatic bit model_lit(int k);
    int slot;
    if (m_lamp) return 1'b1;
    slot = m_cnt / 16;
    case (m_mode[k])
      1: return 1'b1;
      2: return ((m_cnt / 128) % 2) == 1;
      3: return ((m_cnt / 32) % 2) == 1;
      4: return (slot % 2 == 0) && (slot / 2 < m_arg[k]);
      5: return m_timer[k] > 0;
      default: return 1'b0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  function automatic void model_step();
    logic [NL-1:0] nl;
    bit sample;
    for (int k = 0; k < NL; k++) nl[k] = ~model_lit(k);
    for (int k = 0; k < NL; k++) begin
      if (event_i[k])          m_timer[k] = FL;
      else if (m_timer[k] > 0) m_timer[k] = m_timer[k] - 1;
    end
    m_cnt = (m_cnt + 1) % (1 << CW);
    if (cfg_we && int'(cfg_addr) < NL) begin
      m_mode[cfg_addr] = int'(cfg_mode);
      m_arg[cfg_addr]  = int'(cfg_arg);
    end
    sample = m_d2;
    m_d2   = m_d1;
    m_d1   = btn_user;
    m_press = 0;
    if ((m_held && sample) || (!m_held && !sample)) begin
      m_run++;
      if (m_run == DB) begin
        m_held  = !m_held;
        m_run   = 0;
        m_press = m_held;
      end
    end else begin
      m_run = 0;
    end
    if (m_press) m_lamp = !m_lamp;
    m_led = nl;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk_27m);
    #1;
    check_val("led", 32'(led), 32'(m_led));
    check_val("btn_press", 32'(btn_press), 32'(m_press));
    check_val("lamp_test", 32'(lamp_test), 32'(m_lamp));
    cfg_we  = 1'b0;
    event_i = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int pc;
    int pidx;
    int btn_left;

    // Reset values
    repeat (3) @(posedge clk_27m);
    #1;
    check_val("rst_led", 32'(led), 32'h3f);
    check_val("rst_press", 32'(btn_press), 32'h0);
    check_val("rst_lamp", 32'(lamp_test), 32'h0);
    rst_n = 1'b1;
    model_reset();

    // Heartbeat on channel 0
    for (int i = 1; i <= 257; i++) begin
      tick();
      if (i == 128) check_val("hb_c128", 32'(led[0]), 32'h1);
      if (i == 129) check_val("hb_c129", 32'(led[0]), 32'h0);
      if (i == 256) check_val("hb_c256", 32'(led[0]), 32'h0);
      if (i == 257) check_val("hb_c257", 32'(led[0]), 32'h1);
      if (i == 200) check_val("hb_others", 32'(led[5:1]), 32'h1f);
    end

    // Burst with two pulses on channel 1
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_mode = 3'd4; cfg_arg = 3'd2;
    tick();
    n = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (!led[1]) n++;
    end
    check_val("burst_lit_cycles", 32'(n), 32'd32);

    // One-shot on channel 2
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_mode = 3'd5; cfg_arg = 3'd0;
    tick();
    n = 0;
    event_i[2] = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (!led[2]) n++;
    end
    check_val("oneshot_len", 32'(n), 32'd10);

    // Retrigger five cycles after the first pulse
    n = 0;
    for (int i = 0; i < 35; i++) begin
      if (i == 0 || i == 5) event_i[2] = 1'b1;
      tick();
      if (!led[2]) n++;
    end
    check_val("retrigger_len", 32'(n), 32'd15);

    // Writes to non-existent channels
    cfg_we = 1'b1; cfg_addr = 3'd7; cfg_mode = 3'd1; cfg_arg = 3'd7;
    tick();
    cfg_we = 1'b1; cfg_addr = 3'd6; cfg_mode = 3'd1; cfg_arg = 3'd7;
    tick();
    for (int i = 0; i < 300; i++) tick();

    // Bouncing button: three-cycle glitches must not register
    pc = 0;
    for (int g = 0; g < 5; g++) begin
      btn_user = 1'b0;
      repeat (3) begin tick(); if (btn_press) pc++; end
      btn_user = 1'b1;
      repeat (3) begin tick(); if (btn_press) pc++; end
    end
    check_val("bounce_no_press", 32'(pc), 32'd0);

    // Solid press
    pc = 0;
    pidx = 0;
    btn_user = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (btn_press) begin pc++; pidx = i; end
      if (i == 7) check_val("lamp_led_all_on", 32'(led), 32'h0);
    end
    check_val("press_count", 32'(pc), 32'd1);
    check_val("press_latency", 32'(pidx), 32'd6);
    check_val("lamp_on", 32'(lamp_test), 32'h1);
    btn_user = 1'b1;
    repeat (12) tick();

    // Reset asserted while a press is still being debounced
    btn_user = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_pw_led", 32'(led), 32'h3f);
    check_val("rst_pw_press", 32'(btn_press), 32'h0);
    check_val("rst_pw_lamp", 32'(lamp_test), 32'h0);
    model_reset();
    @(posedge clk_27m);
    #1;
    check_val("rst_pw_hold_press", 32'(btn_press), 32'h0);
    btn_user = 1'b1;
    rst_n = 1'b1;
    pc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (btn_press) pc++;
    end
    check_val("rst_pw_no_press", 32'(pc), 32'd0);

    // Randomized traffic
    btn_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        cfg_we   = 1'b1;
        cfg_addr = 3'($urandom_range(0, 7));
        cfg_mode = 3'($urandom_range(0, 7));
        cfg_arg  = 3'($urandom_range(0, 7));
      end
      for (int k = 0; k < NL; k++)
        if ($urandom_range(0, 23) == 0) event_i[k] = 1'b1;
      if (btn_left == 0) begin
        btn_user = 1'($urandom_range(0, 1));
        btn_left = $urandom_range(1, 12);
      end
      btn_left--;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
